// File: rtl/mem_sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_sram_ctrl_pkg
// Shared definitions for the MEM-stage SRAM controller: bus widths, common
// constants and the access FSM state encoding.
// -----------------------------------------------------------------------------
package mem_sram_ctrl_pkg;

    localparam int unsigned REG_BUS_W       = 32;
    localparam int unsigned SRAM_ADDR_BUS_W = 20;
    localparam int unsigned SRAM_BE_BUS_W   = 4;

    typedef logic [REG_BUS_W-1:0]     reg_bus_t;
    typedef logic [SRAM_BE_BUS_W-1:0] sram_be_bus_t;

    localparam reg_bus_t ZERO_WORD = 32'h0000_0000;
    // Value of a stall request that freezes the pipeline.
    localparam logic     STOP      = 1'b1;

    typedef enum logic [2:0] {
        SRAM_IDLE  = 3'd0,
        SRAM_READ  = 3'd1,
        SRAM_WRITE = 3'd2,
        SRAM_WREC  = 3'd3,
        SRAM_DONE  = 3'd4
    } sram_state_e;

endpackage

// File: rtl/mem_sram_ctrl.sv
// -----------------------------------------------------------------------------
// mem_sram_ctrl
// MEM-stage data-memory controller driving an asynchronous 32-bit SRAM.
// A request is latched in IDLE, then a multi-cycle READ or WRITE(+WREC)
// sequence runs while stallreq freezes the earlier pipeline stages.
//
// Ports:
//   cpu_clk_50M, cpu_rst     clock, asynchronous active-high reset
//   mem_req/we/addr/wdata/be load/store request from the EXE/MEM register
//   flush                    exception flush
//   stallreq                 stall request (combinational)
//   mem_rdata(_valid)        load data and its one-cycle strobe
//   sram_*                   registered SRAM pad controls / data
// -----------------------------------------------------------------------------
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = SRAM_ADDR_BUS_W,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_be,
    input  logic              flush,
    output logic              stallreq,
    output logic [31:0]       mem_rdata,
    output logic              mem_rdata_valid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dout,
    output logic              sram_doe,
    input  logic [31:0]       sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    sram_state_e     r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    sram_be_bus_t    r_be, w_be_nxt;

    logic w_accept;
    logic w_cnt_zero;
    logic w_rd_done;
    logic w_busy;

    // Next-cycle pad controls, registered so no pipeline path reaches the pads.
    logic         w_ce_n_nxt;
    logic         w_oe_n_nxt;
    logic         w_we_n_nxt;
    logic         w_doe_nxt;
    sram_be_bus_t w_be_n_nxt;

    logic w_unused_addr;
    assign w_unused_addr = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    assign w_accept   = (r_state == SRAM_IDLE) && mem_req && !flush;
    assign w_cnt_zero = (r_cnt == '0);
    // A flushed read is abandoned, so its data is neither captured nor flagged.
    assign w_rd_done  = (r_state == SRAM_READ) && w_cnt_zero && !flush;

    assign w_busy   = w_accept || (r_state == SRAM_READ) || (r_state == SRAM_WRITE) ||
                      (r_state == SRAM_WREC);
    assign stallreq = (w_busy && !flush) ? STOP : ~STOP;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_be_nxt    = r_be;
        case (r_state)
            SRAM_IDLE: begin
                if (w_accept) begin
                    w_be_nxt = mem_be;
                    if (mem_we) begin
                        w_state_nxt = SRAM_WRITE;
                        w_cnt_nxt   = CNT_W'(WR_WAIT - 1);
                    end else begin
                        w_state_nxt = SRAM_READ;
                        w_cnt_nxt   = CNT_W'(RD_WAIT - 1);
                    end
                end
            end
            SRAM_READ: begin
                if (flush) begin
                    w_state_nxt = SRAM_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_zero) begin
                    w_state_nxt = SRAM_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            // Writes ignore flush so the SRAM never sees a truncated we_n pulse.
            SRAM_WRITE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = SRAM_WREC;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            SRAM_WREC: w_state_nxt = SRAM_DONE;
            SRAM_DONE: w_state_nxt = SRAM_IDLE;
            default:   w_state_nxt = SRAM_IDLE;
        endcase
    end

    always_comb begin
        w_ce_n_nxt = 1'b1;
        w_oe_n_nxt = 1'b1;
        w_we_n_nxt = 1'b1;
        w_doe_nxt  = 1'b0;
        w_be_n_nxt = 4'hF;
        case (w_state_nxt)
            SRAM_READ: begin
                w_ce_n_nxt = 1'b0;
                w_oe_n_nxt = 1'b0;
                w_be_n_nxt = ~w_be_nxt;
            end
            SRAM_WRITE: begin
                w_ce_n_nxt = 1'b0;
                w_we_n_nxt = 1'b0;
                w_doe_nxt  = 1'b1;
                w_be_n_nxt = ~w_be_nxt;
            end
            // Keep driving the bus one cycle after we_n rises for data hold.
            SRAM_WREC: w_doe_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state         <= SRAM_IDLE;
            r_cnt           <= '0;
            r_be            <= '0;
            sram_ce_n       <= 1'b1;
            sram_oe_n       <= 1'b1;
            sram_we_n       <= 1'b1;
            sram_doe        <= 1'b0;
            sram_be_n       <= 4'hF;
            sram_addr       <= '0;
            sram_dout       <= ZERO_WORD;
            mem_rdata       <= ZERO_WORD;
            mem_rdata_valid <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_be            <= w_be_nxt;
            sram_ce_n       <= w_ce_n_nxt;
            sram_oe_n       <= w_oe_n_nxt;
            sram_we_n       <= w_we_n_nxt;
            sram_doe        <= w_doe_nxt;
            sram_be_n       <= w_be_n_nxt;
            mem_rdata_valid <= w_rd_done;
            if (w_accept) begin
                sram_addr <= mem_addr[ADDR_W+1:2];
            end
            if (w_accept && mem_we) begin
                sram_dout <= mem_wdata;
            end
            if (w_rd_done) begin
                mem_rdata <= sram_din;
            end
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_sram_ctrl
// Directed bench for mem_sram_ctrl with a 16-word SRAM model and a per-cycle
// monitor counting strobe cycles, stall cycles and load-valid pulses.
// -----------------------------------------------------------------------------
module tb_mem_sram_ctrl;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst     = 1'b1;
    logic        mem_req     = 1'b0;
    logic        mem_we      = 1'b0;
    logic [31:0] mem_addr    = '0;
    logic [31:0] mem_wdata   = '0;
    logic [3:0]  mem_be      = '0;
    logic        flush       = 1'b0;
    logic        stallreq;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic [19:0] sram_addr;
    logic [31:0] sram_dout;
    logic        sram_doe;
    logic [31:0] sram_din;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    int n_cmp = 0;
    int n_err = 0;

    mem_sram_ctrl #(
        .ADDR_W  (20),
        .RD_WAIT (2),
        .WR_WAIT (2)
    ) u_dut (
        .cpu_clk_50M     (cpu_clk_50M),
        .cpu_rst         (cpu_rst),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .flush           (flush),
        .stallreq        (stallreq),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .sram_addr       (sram_addr),
        .sram_dout       (sram_dout),
        .sram_doe        (sram_doe),
        .sram_din        (sram_din),
        .sram_ce_n       (sram_ce_n),
        .sram_oe_n       (sram_oe_n),
        .sram_we_n       (sram_we_n),
        .sram_be_n       (sram_be_n)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    // SRAM model: combinational read, byte-lane write sampled each clock.
    logic [31:0] sram_mem [16];
    assign sram_din = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[3:0]] : 32'h0;

    always @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            for (int i = 0; i < 16; i++) sram_mem[i] <= 32'h0;
            sram_mem[2] <= 32'h1122_3344;
            sram_mem[4] <= 32'hDEAD_BEEF;
            sram_mem[5] <= 32'h5566_7788;
            sram_mem[6] <= 32'hCAFE_F00D;
        end else if (!sram_ce_n && !sram_we_n) begin
            for (int i = 0; i < 4; i++) begin
                if (!sram_be_n[i]) sram_mem[sram_addr[3:0]][8*i +: 8] <= sram_dout[8*i +: 8];
            end
        end
    end

    // Monitor
    logic        mon_clr = 1'b0;
    logic        mon_en  = 1'b0;
    int          n_oe, n_we, n_doe, n_stall, n_valid, n_merge, n_runs, mon_cyc, valid_cyc;
    logic [31:0] rdata_seen;
    logic [19:0] addr_seen;
    logic [3:0]  be_n_seen;
    logic        prev_ce_n;

    always @(negedge cpu_clk_50M) begin
        if (mon_clr) begin
            n_oe <= 0; n_we <= 0; n_doe <= 0; n_stall <= 0; n_valid <= 0;
            n_merge <= 0; n_runs <= 0; mon_cyc <= 0; valid_cyc <= -1;
            rdata_seen <= '0; addr_seen <= '0; be_n_seen <= 4'hF; prev_ce_n <= 1'b1;
        end else if (mon_en) begin
            mon_cyc <= mon_cyc + 1;
            if (!sram_oe_n) n_oe <= n_oe + 1;
            if (!sram_we_n) n_we <= n_we + 1;
            if (sram_doe) n_doe <= n_doe + 1;
            if (stallreq) n_stall <= n_stall + 1;
            if (!sram_oe_n && !sram_we_n) n_merge <= n_merge + 1;
            if (!sram_ce_n && prev_ce_n) n_runs <= n_runs + 1;
            prev_ce_n <= sram_ce_n;
            if (!sram_ce_n) begin
                addr_seen <= sram_addr;
                be_n_seen <= sram_be_n;
            end
            if (mem_rdata_valid) begin
                n_valid    <= n_valid + 1;
                valid_cyc  <= mon_cyc;
                rdata_seen <= mem_rdata;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Ends at posedge+1 with monitor cleared and enabled.
    task automatic mon_start();
        @(posedge cpu_clk_50M); #1;
        mon_clr = 1'b1;
        @(negedge cpu_clk_50M); #1;
        mon_clr = 1'b0;
        @(posedge cpu_clk_50M); #1;
        mon_en = 1'b1;
    endtask

    task automatic mon_stop();
        repeat (3) @(negedge cpu_clk_50M);
        #1 mon_en = 1'b0;
    endtask

    task automatic idle_inputs();
        mem_req = 1'b0;
        mem_we  = 1'b0;
        mem_be  = 4'h0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the IDLE cycle after DONE.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        int k;
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_be    = be;
        for (k = 0; k < 20; k++) begin
            @(negedge cpu_clk_50M);
            if (!stallreq) break;
        end
        if (k == 20) check_eq("access_timeout", 32'(stallreq), 32'h0);
        @(posedge cpu_clk_50M); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge cpu_clk_50M);
        #1;
        check_eq("rst_stallreq", 32'(stallreq), 32'h0);
        check_eq("rst_rdata", mem_rdata, 32'h0);
        check_eq("rst_valid", 32'(mem_rdata_valid), 32'h0);
        check_eq("rst_ce_oe_we", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        check_eq("rst_be_n", 32'(sram_be_n), 32'hF);
        check_eq("rst_doe", 32'(sram_doe), 32'h0);
        check_eq("rst_addr", 32'(sram_addr), 32'h0);
        check_eq("rst_dout", sram_dout, 32'h0);
        @(negedge cpu_clk_50M);
        cpu_rst = 1'b0;

        // Single load from word 4
        mon_start();
        issue(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        idle_inputs();
        mon_stop();
        check_eq("ld_addr", 32'(addr_seen), 32'h4);
        check_eq("ld_be_n", 32'(be_n_seen), 32'h0);
        check_eq("ld_oe_cycles", 32'(n_oe), 32'd2);
        check_eq("ld_we_cycles", 32'(n_we), 32'd0);
        check_eq("ld_stall_cycles", 32'(n_stall), 32'd3);
        check_eq("ld_valid_count", 32'(n_valid), 32'd1);
        check_eq("ld_valid_cycle", 32'(valid_cyc), 32'd3);
        check_eq("ld_rdata", rdata_seen, 32'hDEAD_BEEF);

        // Single byte store to word 2, lane 0
        mon_start();
        issue(1'b1, 32'h0000_0008, 32'h0000_00AB, 4'b0001);
        idle_inputs();
        mon_stop();
        check_eq("st_addr", 32'(addr_seen), 32'h2);
        check_eq("st_be_n", 32'(be_n_seen), 32'hE);
        check_eq("st_we_cycles", 32'(n_we), 32'd2);
        check_eq("st_oe_cycles", 32'(n_oe), 32'd0);
        check_eq("st_doe_cycles", 32'(n_doe), 32'd3);
        check_eq("st_stall_cycles", 32'(n_stall), 32'd4);
        check_eq("st_valid_count", 32'(n_valid), 32'd0);
        check_eq("st_mem_word2", sram_mem[2], 32'h1122_33AB);

        // Back-to-back load, store (lane 1 of word 5), load of word 5
        mon_start();
        issue(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        issue(1'b1, 32'h0000_0014, 32'h0000_CD00, 4'b0010);
        issue(1'b0, 32'h0000_0014, 32'h0, 4'hF);
        idle_inputs();
        mon_stop();
        check_eq("b2b_valid_count", 32'(n_valid), 32'd2);
        check_eq("b2b_oe_cycles", 32'(n_oe), 32'd4);
        check_eq("b2b_we_cycles", 32'(n_we), 32'd2);
        check_eq("b2b_merged", 32'(n_merge), 32'd0);
        check_eq("b2b_ce_runs", 32'(n_runs), 32'd3);
        check_eq("b2b_stall_cycles", 32'(n_stall), 32'd10);
        check_eq("b2b_rdata", rdata_seen, 32'h5566_CD88);

        // Flush in the second READ cycle
        mon_start();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0018; mem_be = 4'hF;
        @(posedge cpu_clk_50M); #1;
        @(posedge cpu_clk_50M); #1;
        flush = 1'b1;
        @(negedge cpu_clk_50M);
        check_eq("flrd_stall_same_cycle", 32'(stallreq), 32'h0);
        @(posedge cpu_clk_50M); #1;
        flush = 1'b0;
        idle_inputs();
        @(negedge cpu_clk_50M);
        check_eq("flrd_ce_n", 32'(sram_ce_n), 32'h1);
        check_eq("flrd_oe_n", 32'(sram_oe_n), 32'h1);
        mon_stop();
        check_eq("flrd_valid_count", 32'(n_valid), 32'd0);
        check_eq("flrd_oe_cycles", 32'(n_oe), 32'd2);
        check_eq("flrd_stall_after", 32'(stallreq), 32'h0);

        // Flush during WRITE: the write still completes
        mon_start();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_000C;
        mem_wdata = 32'h0BAD_F00D; mem_be = 4'hF;
        @(posedge cpu_clk_50M); #1;
        flush = 1'b1;
        idle_inputs();
        @(negedge cpu_clk_50M);
        check_eq("flwr_stall_c1", 32'(stallreq), 32'h0);
        check_eq("flwr_we_n_c1", 32'(sram_we_n), 32'h0);
        @(posedge cpu_clk_50M); #1;
        @(negedge cpu_clk_50M);
        check_eq("flwr_stall_c2", 32'(stallreq), 32'h0);
        @(posedge cpu_clk_50M); #1;
        flush = 1'b0;
        mon_stop();
        check_eq("flwr_we_cycles", 32'(n_we), 32'd2);
        check_eq("flwr_doe_cycles", 32'(n_doe), 32'd3);
        check_eq("flwr_stall_cycles", 32'(n_stall), 32'd2);
        check_eq("flwr_mem_word3", sram_mem[3], 32'h0BAD_F00D);

        // Asynchronous reset in the middle of a WRITE
        @(posedge cpu_clk_50M); #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0020;
        mem_wdata = 32'h1234_5678; mem_be = 4'hF;
        @(posedge cpu_clk_50M); #1;
        idle_inputs();
        @(negedge cpu_clk_50M);
        check_eq("rstw_we_n_before", 32'(sram_we_n), 32'h0);
        #2 cpu_rst = 1'b1;
        #1;
        check_eq("rstw_we_n", 32'(sram_we_n), 32'h1);
        check_eq("rstw_ce_n", 32'(sram_ce_n), 32'h1);
        check_eq("rstw_doe", 32'(sram_doe), 32'h0);
        check_eq("rstw_be_n", 32'(sram_be_n), 32'hF);
        check_eq("rstw_stall", 32'(stallreq), 32'h0);
        @(negedge cpu_clk_50M);
        @(negedge cpu_clk_50M);
        cpu_rst = 1'b0;

        // Load after reset recovery
        mon_start();
        issue(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        idle_inputs();
        mon_stop();
        check_eq("rstw_ld_valid_count", 32'(n_valid), 32'd1);
        check_eq("rstw_ld_oe_cycles", 32'(n_oe), 32'd2);
        check_eq("rstw_ld_rdata", rdata_seen, 32'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
